// File: rtl/rr_stream_merge.sv
// rr_stream_merge: round-robin merge of NCH valid/ready producer streams into
// one output stream tagged with the source channel id. Accepted beats land in
// a 2-entry registered FIFO, so input readies never see o_ready directly.
// PKT_MODE=1 keeps the grant on one channel until its last beat is accepted.
module rr_stream_merge #(
  parameter  int NCH      = 4,
  parameter  int DW       = 16,
  parameter  int PKT_MODE = 0,
  localparam int IDW      = $clog2(NCH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NCH-1:0]      i_valid,
  output logic [NCH-1:0]      i_ready,
  input  logic [NCH*DW-1:0]   i_data,
  input  logic [NCH-1:0]      i_last,
  output logic                o_valid,
  input  logic                o_ready,
  output logic [DW-1:0]       o_data,
  output logic                o_last,
  output logic [IDW-1:0]      o_id
);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t           state;
  state_t           state_next;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   lock_ch;

  logic [1:0]       count;
  logic             wr_ptr;
  logic             rd_ptr;
  logic [DW-1:0]    mem_data [2];
  logic             mem_last [2];
  logic [IDW-1:0]   mem_id   [2];

  logic [IDW-1:0]   rr_grant;
  logic             rr_found;
  logic [IDW-1:0]   grant;
  logic             arb_ok;
  logic             accept;
  logic             pop;
  logic [DW-1:0]    acc_data;
  logic             acc_last;

  // Round-robin search: first valid channel after the last served one.
  always_comb begin
    logic [IDW-1:0] idx;
    rr_grant = '0;
    rr_found = 1'b0;
    idx      = '0;
    for (int k = 1; k <= NCH; k++) begin
      idx = IDW'((int'(ptr) + k) % NCH);
      if (!rr_found && i_valid[idx]) begin
        rr_found = 1'b1;
        rr_grant = idx;
      end
    end
  end

  // Grant selection: a packet lock pins the grant even through valid bubbles.
  always_comb begin
    grant  = rr_grant;
    arb_ok = rr_found;
    if (PKT_MODE != 0 && state == LOCK) begin
      grant  = lock_ch;
      arb_ok = 1'b1;
    end
  end

  // Readies depend only on registered state and i_valid; gated low in reset.
  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ready
      assign i_ready[gi] = rst && (count < 2'd2) && arb_ok && (grant == IDW'(gi));
    end
  endgenerate

  assign accept   = |(i_valid & i_ready);
  assign acc_data = i_data[int'(grant)*DW +: DW];
  assign acc_last = i_last[grant];
  assign pop      = o_valid && o_ready;

  // Packet-lock next state; mode 0 never leaves IDLE.
  always_comb begin
    state_next = state;
    if (PKT_MODE != 0 && accept) begin
      if (state == IDLE && !acc_last) begin
        state_next = LOCK;
      end else if (state == LOCK && acc_last) begin
        state_next = IDLE;
      end
    end
  end

  // Arbitration state: FSM, locked channel and round-robin pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      lock_ch <= '0;
      ptr     <= IDW'(NCH - 1);
    end else begin
      state <= state_next;
      if (accept) begin
        ptr <= grant;
        if (state == IDLE) begin
          lock_ch <= grant;
        end
      end
    end
  end

  // Two-entry output FIFO; push and pop in one cycle leave the count alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      for (int j = 0; j < 2; j++) begin
        mem_data[j] <= '0;
        mem_last[j] <= 1'b0;
        mem_id[j]   <= '0;
      end
    end else begin
      if (accept) begin
        mem_data[wr_ptr] <= acc_data;
        mem_last[wr_ptr] <= acc_last;
        mem_id[wr_ptr]   <= grant;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({accept, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign o_valid = (count != 2'd0);
  assign o_data  = mem_data[rd_ptr];
  assign o_last  = mem_last[rd_ptr];
  assign o_id    = mem_id[rd_ptr];

endmodule

// File: tb/tb_rr_stream_merge.sv
// tb_rr_stream_merge: directed table for NCH=4 in both modes, a hand-written
// packet-lock sequence, reset mid-traffic, and a random scoreboard on NCH=3.
module tb_rr_stream_merge;

  logic clk;
  logic rst;

  // NCH=4, DW=16 instances: index 0 = PKT_MODE 0, index 1 = PKT_MODE 1
  logic [3:0]  v    [2];
  logic [3:0]  l    [2];
  logic [63:0] d    [2];
  logic        ordy [2];
  logic [3:0]  ir   [2];
  logic        ov   [2];
  logic [15:0] od   [2];
  logic        ol   [2];
  logic [1:0]  oid  [2];

  // NCH=3, DW=8 random instances: index 0 = PKT_MODE 0, index 1 = PKT_MODE 1
  logic [2:0]  rv   [2];
  logic [2:0]  rl   [2];
  logic [23:0] rd   [2];
  logic        ro   [2];
  logic [2:0]  rir  [2];
  logic        rov  [2];
  logic [7:0]  rod  [2];
  logic        rol  [2];
  logic [1:0]  roid [2];

  int checks = 0;
  int errors = 0;

  rr_stream_merge #(.NCH(4), .DW(16), .PKT_MODE(0)) u_dut0 (
    .clk(clk), .rst(rst), .i_valid(v[0]), .i_ready(ir[0]), .i_data(d[0]),
    .i_last(l[0]), .o_valid(ov[0]), .o_ready(ordy[0]), .o_data(od[0]),
    .o_last(ol[0]), .o_id(oid[0]));

  rr_stream_merge #(.NCH(4), .DW(16), .PKT_MODE(1)) u_dut1 (
    .clk(clk), .rst(rst), .i_valid(v[1]), .i_ready(ir[1]), .i_data(d[1]),
    .i_last(l[1]), .o_valid(ov[1]), .o_ready(ordy[1]), .o_data(od[1]),
    .o_last(ol[1]), .o_id(oid[1]));

  rr_stream_merge #(.NCH(3), .DW(8), .PKT_MODE(0)) u_rnd0 (
    .clk(clk), .rst(rst), .i_valid(rv[0]), .i_ready(rir[0]), .i_data(rd[0]),
    .i_last(rl[0]), .o_valid(rov[0]), .o_ready(ro[0]), .o_data(rod[0]),
    .o_last(rol[0]), .o_id(roid[0]));

  rr_stream_merge #(.NCH(3), .DW(8), .PKT_MODE(1)) u_rnd1 (
    .clk(clk), .rst(rst), .i_valid(rv[1]), .i_ready(rir[1]), .i_data(rd[1]),
    .i_last(rl[1]), .o_valid(rov[1]), .o_ready(ro[1]), .o_data(rod[1]),
    .o_last(rol[1]), .o_id(roid[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  v;
    logic        r;
    logic [3:0]  er;
    logic        ov;
    logic [1:0]  oid;
    logic [15:0] od;
  } vec_t;

  vec_t tbl [23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Channel c carries 16'(c*4096 + tag) so every beat is traceable.
  function automatic logic [63:0] mkdata(input int tag);
    logic [63:0] x;
    for (int c = 0; c < 4; c++) x[c*16 +: 16] = 16'(c * 4096 + tag);
    return x;
  endfunction

  // One cycle of the packet-lock sequence on the PKT_MODE=1 instance.
  task automatic lk(input logic [3:0] vv, input logic [3:0] ll, input logic [3:0] er,
                    input logic eov, input logic [1:0] eid, input logic elast,
                    input logic [15:0] edata, input int step);
    @(posedge clk); #1;
    v[1] = vv; l[1] = ll; d[1] = mkdata(60 + step); ordy[1] = 1'b1;
    v[0] = 4'b0000;
    @(negedge clk);
    chk("lock_ready", 32'(ir[1]), 32'(er));
    chk("lock_ovalid", 32'(ov[1]), 32'(eov));
    if (eov) begin
      chk("lock_oid", 32'(oid[1]), 32'(eid));
      chk("lock_olast", 32'(ol[1]), 32'(elast));
      chk("lock_odata", 32'(od[1]), 32'(edata));
    end
    $display("lock step %0d valid=%b ready=%b o_valid=%0d o_id=%0d", step, vv, ir[1], ov[1], oid[1]);
  endtask

  // random scoreboard state
  int  in_seq   [2][3];
  int  out_seq  [2][3];
  int  wait_cnt [2][3];
  bit  last_hist[2][3][64];
  bit  mid_pkt  [2][3];
  logic [2:0] nv [2];
  logic [2:0] nl [2];
  logic       nr [2];
  logic [2:0] acc;
  logic [2:0] others;
  int         pc;
  bit         drain;

  initial begin
    tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0, 16'h0000};
    tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0, 16'h0000};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1, 16'h1001};
    tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd2, 16'h2002};
    tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd3, 16'h3003};
    tbl[5]  = '{4'b0101, 1'b1, 4'b0100, 1'b1, 2'd0, 16'h0004};
    tbl[6]  = '{4'b0101, 1'b1, 4'b0001, 1'b1, 2'd2, 16'h2005};
    tbl[7]  = '{4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 16'h0006};
    tbl[8]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 16'h0007};
    tbl[9]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 16'h0000};
    tbl[10] = '{4'b0100, 1'b0, 4'b0100, 1'b0, 2'd0, 16'h0000};
    tbl[11] = '{4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, 16'h200A};
    tbl[12] = '{4'b0100, 1'b0, 4'b0000, 1'b1, 2'd2, 16'h200A};
    tbl[13] = '{4'b0100, 1'b0, 4'b0000, 1'b1, 2'd2, 16'h200A};
    tbl[14] = '{4'b0100, 1'b0, 4'b0000, 1'b1, 2'd2, 16'h200A};
    tbl[15] = '{4'b0100, 1'b1, 4'b0000, 1'b1, 2'd2, 16'h200A};
    tbl[16] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 16'h200B};
    tbl[17] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2, 16'h2010};
    tbl[18] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 16'h0000};
    tbl[19] = '{4'b1001, 1'b1, 4'b1000, 1'b0, 2'd0, 16'h0000};
    tbl[20] = '{4'b1001, 1'b1, 4'b0001, 1'b1, 2'd3, 16'h3013};
    tbl[21] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 16'h0014};
    tbl[22] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 16'h0000};

    rst = 1'b0;
    for (int m = 0; m < 2; m++) begin
      v[m] = 4'b1111; l[m] = 4'b0000; d[m] = mkdata(0); ordy[m] = 1'b1;
      rv[m] = 3'b000; rl[m] = 3'b000; rd[m] = '0; ro[m] = 1'b1;
      nv[m] = 3'b000; nl[m] = 3'b000; nr[m] = 1'b1;
      for (int c = 0; c < 3; c++) begin
        in_seq[m][c] = 0; out_seq[m][c] = 0; wait_cnt[m][c] = 0; mid_pkt[m][c] = 1'b0;
      end
    end

    // reset values, with every channel requesting
    #12;
    for (int m = 0; m < 2; m++) begin
      chk("reset_ready", 32'(ir[m]), 32'd0);
      chk("reset_ovalid", 32'(ov[m]), 32'd0);
      chk("reset_odata", 32'(od[m]), 32'd0);
      chk("reset_olast", 32'(ol[m]), 32'd0);
      chk("reset_oid", 32'(oid[m]), 32'd0);
    end
    for (int m = 0; m < 2; m++) v[m] = 4'b0000;
    #10 rst = 1'b1;

    // directed table: mode 0 (last=0) and mode 1 with single-beat packets
    for (int r = 0; r < 23; r++) begin
      @(posedge clk); #1;
      for (int m = 0; m < 2; m++) begin
        v[m] = tbl[r].v; l[m] = (m == 1) ? 4'b1111 : 4'b0000;
        d[m] = mkdata(r); ordy[m] = tbl[r].r;
      end
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        chk("tbl_ready", 32'(ir[m]), 32'(tbl[r].er));
        chk("tbl_ovalid", 32'(ov[m]), 32'(tbl[r].ov));
        if (tbl[r].ov) begin
          chk("tbl_oid", 32'(oid[m]), 32'(tbl[r].oid));
          chk("tbl_odata", 32'(od[m]), 32'(tbl[r].od));
          chk("tbl_olast", 32'(ol[m]), 32'(m == 1));
        end
      end
      $display("row %0d valid=%b o_ready=%0d ready0=%b ready1=%b o_id0=%0d o_data0=%h",
               r, tbl[r].v, tbl[r].r, ir[0], ir[1], oid[0], od[0]);
    end

    // reset in the middle of traffic with full FIFOs
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      for (int m = 0; m < 2; m++) begin
        v[m] = 4'b1111; ordy[m] = 1'b0; d[m] = mkdata(40 + k);
      end
    end
    @(posedge clk); #3;
    rst = 1'b0;
    #2;
    for (int m = 0; m < 2; m++) begin
      chk("midrst_ready_a", 32'(ir[m]), 32'd0);
      chk("midrst_ovalid_a", 32'(ov[m]), 32'd0);
    end
    #26;
    for (int m = 0; m < 2; m++) begin
      chk("midrst_ready_b", 32'(ir[m]), 32'd0);
      chk("midrst_ovalid_b", 32'(ov[m]), 32'd0);
    end
    #2;
    for (int m = 0; m < 2; m++) ordy[m] = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      chk("postrst_ready", 32'(ir[m]), 32'b0001);
      chk("postrst_ovalid", 32'(ov[m]), 32'd0);
    end
    $display("reset release ready0=%b ready1=%b", ir[0], ir[1]);
    @(posedge clk); #1;
    for (int m = 0; m < 2; m++) v[m] = 4'b0000;
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      chk("postrst_ovalid2", 32'(ov[m]), 32'd1);
      chk("postrst_oid", 32'(oid[m]), 32'd0);
      chk("postrst_odata", 32'(od[m]), 32'h002A);
    end
    $display("first beat after reset o_id0=%0d o_id1=%0d", oid[0], oid[1]);

    // packet lock: ch1 3-beat packet with 2-cycle bubble, ch0/ch3 waiting
    lk(4'b1011, 4'b1001, 4'b0010, 1'b0, 2'd0, 1'b0, 16'h0000, 0);
    lk(4'b1001, 4'b1001, 4'b0010, 1'b1, 2'd1, 1'b0, 16'h103C, 1);
    lk(4'b1001, 4'b1001, 4'b0010, 1'b0, 2'd0, 1'b0, 16'h0000, 2);
    lk(4'b1011, 4'b1001, 4'b0010, 1'b0, 2'd0, 1'b0, 16'h0000, 3);
    lk(4'b1011, 4'b1011, 4'b0010, 1'b1, 2'd1, 1'b0, 16'h103F, 4);
    lk(4'b1001, 4'b1001, 4'b1000, 1'b1, 2'd1, 1'b1, 16'h1040, 5);
    lk(4'b0001, 4'b1001, 4'b0001, 1'b1, 2'd3, 1'b1, 16'h3041, 6);
    lk(4'b0000, 4'b1001, 4'b0000, 1'b1, 2'd0, 1'b1, 16'h0042, 7);
    lk(4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 16'h0000, 8);

    // random scoreboard on NCH=3, both modes, then a drain that closes packets
    for (int cyc = 0; cyc < 10060; cyc++) begin
      drain = (cyc >= 10000);
      @(posedge clk); #1;
      for (int m = 0; m < 2; m++) begin
        rv[m] = nv[m]; rl[m] = nl[m]; ro[m] = nr[m];
        for (int c = 0; c < 3; c++) rd[m][c*8 +: 8] = {2'(c), 6'(in_seq[m][c])};
      end
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        chk("rnd_onehot", 32'($countones(rir[m]) <= 1), 32'd1);
        if (rov[m] && ro[m]) begin
          pc = int'(roid[m]);
          chk("rnd_id_range", 32'(pc < 3), 32'd1);
          if (pc < 3) begin
            chk("rnd_nonempty", 32'(out_seq[m][pc] < in_seq[m][pc]), 32'd1);
            chk("rnd_data", 32'(rod[m]), 32'({2'(pc), 6'(out_seq[m][pc])}));
            chk("rnd_last", 32'(rol[m]), 32'(last_hist[m][pc][out_seq[m][pc] % 64]));
            out_seq[m][pc]++;
          end
        end
        acc = rv[m] & rir[m];
        for (int c = 0; c < 3; c++) begin
          others = acc & ~(3'b001 << c);
          if (m == 1) others = others & rl[m];
          if (acc[c]) begin
            chk("rnd_starve", 32'(wait_cnt[m][c] <= 3), 32'd1);
            wait_cnt[m][c] = 0;
            last_hist[m][c][in_seq[m][c] % 64] = rl[m][c];
            mid_pkt[m][c] = !rl[m][c];
            in_seq[m][c]++;
          end else if (rv[m][c] && others != 3'b000) begin
            wait_cnt[m][c]++;
          end
          if (acc[c] || !rv[m][c]) begin
            if (!drain) begin
              nv[m][c] = ($urandom_range(0, 99) < 55);
              nl[m][c] = ($urandom_range(0, 2) == 0);
            end else begin
              nv[m][c] = mid_pkt[m][c];
              nl[m][c] = 1'b1;
            end
          end
        end
        nr[m] = drain ? 1'b1 : ($urandom_range(0, 99) < 70);
      end
    end
    for (int m = 0; m < 2; m++) begin
      for (int c = 0; c < 3; c++) begin
        chk("rnd_drained", 32'(out_seq[m][c]), 32'(in_seq[m][c]));
        chk("rnd_pending", 32'(nv[m][c]), 32'd0);
      end
      $display("random mode %0d beats ch0=%0d ch1=%0d ch2=%0d", m,
               out_seq[m][0], out_seq[m][1], out_seq[m][2]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
